// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the CPU memory/I-O bus: I/O register map and STATUS bit layout.
package cpu_bus_pkg;

    localparam logic [7:0] IO_DATA   = 8'h00;
    localparam logic [7:0] IO_STATUS = 8'h01;

    localparam int ST_IN_NE    = 0;
    localparam int ST_OUT_FULL = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_UDF      = 3;

    function automatic logic [7:0] pack_status(input logic udf, input logic ovf,
                                               input logic out_full, input logic in_nonempty);
        logic [7:0] s;
        s              = '0;
        s[ST_UDF]      = udf;
        s[ST_OVF]      = ovf;
        s[ST_OUT_FULL] = out_full;
        s[ST_IN_NE]    = in_nonempty;
        return s;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU-side strobes, program loader and the two streaming I/O ports of the memory/I-O target.
interface mem_io_responder_if;

    logic [7:0] addr_bus;
    logic       c_ri;
    logic       c_ro;
    logic       mem_clk;
    logic       mem_io;
    logic       load_en;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output addr_bus, c_ri, c_ro, mem_clk, mem_io,
        output load_en, load_addr, load_data,
        input  out_data, out_valid,
        output out_ready,
        output in_data, in_valid,
        input  in_ready
    );

    modport slave (
        input  addr_bus, c_ri, c_ro, mem_clk, mem_io,
        input  load_en, load_addr, load_data,
        output out_data, out_valid,
        input  out_ready,
        input  in_data, in_valid,
        output in_ready
    );

endinterface

// File: rtl/mem_io_responder_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is taken only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory/I-O target on the CPU's shared tri-state bus: 256-byte RAM, output/input FIFOs,
// a STATUS register with sticky overflow/underflow flags, and a program-load port.
module mem_io_responder
    import cpu_bus_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int FIFO_DEPTH = 4,
    parameter     INIT_FILE  = ""
) (
    input  logic               clk,
    input  logic               reset,
    mem_io_responder_if.slave  io,
    inout  wire  [7:0]         bus
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [7:0] ram [MEM_DEPTH];

    function automatic logic [AW-1:0] ram_index(input logic [7:0] a);
        return AW'(32'(a) % MEM_DEPTH);
    endfunction

    logic [7:0] bus_in;
    logic [7:0] rd_data;
    logic       io_data_sel;
    logic       io_status_sel;
    logic       cpu_ram_wr;
    logic       out_wr;
    logic       flag_clr;
    logic       in_rd;
    logic       out_push;
    logic       out_pop;
    logic       out_full;
    logic       out_empty;
    logic [7:0] out_dout;
    logic       in_push;
    logic       in_full;
    logic       in_empty;
    logic [7:0] in_dout;
    logic       pop_pending;
    logic       ovf;
    logic       udf;

    assign bus_in        = bus;
    assign io_data_sel   = io.mem_io && (io.addr_bus == IO_DATA);
    assign io_status_sel = io.mem_io && (io.addr_bus == IO_STATUS);
    assign cpu_ram_wr    = io.mem_clk && io.c_ri && !io.mem_io;
    assign out_wr        = io.mem_clk && io.c_ri && io_data_sel;
    assign flag_clr      = io.mem_clk && io.c_ri && io_status_sel;
    assign in_rd         = io.mem_clk && io.c_ro && io_data_sel;

    // A full output FIFO still accepts the CPU byte if the consumer drains one on the same edge.
    assign out_pop  = !out_empty && io.out_ready;
    assign out_push = out_wr && (!out_full || out_pop);
    assign in_push  = io.in_valid && !in_full;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .din   (bus_in),
        .pop   (out_pop),
        .dout  (out_dout),
        .full  (out_full),
        .empty (out_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .din   (io.in_data),
        .pop   (pop_pending),
        .dout  (in_dout),
        .full  (in_full),
        .empty (in_empty)
    );

    assign io.out_data  = out_dout;
    assign io.out_valid = !out_empty;
    assign io.in_ready  = !in_full;

    // The IN pop is deferred one edge so the head stays on the bus until the CPU latches it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_pending <= 1'b0;
            ovf         <= 1'b0;
            udf         <= 1'b0;
        end else begin
            pop_pending <= in_rd && !in_empty;
            if (flag_clr) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (out_wr && !out_push) ovf <= 1'b1;
                if (in_rd && in_empty)   udf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (io.load_en) begin
            ram[ram_index(io.load_addr)] <= io.load_data;
        end else if (cpu_ram_wr) begin
            ram[ram_index(io.addr_bus)] <= bus_in;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (!io.mem_io) begin
            rd_data = ram[ram_index(io.addr_bus)];
        end else if (io_data_sel) begin
            rd_data = in_empty ? 8'h00 : in_dout;
        end else if (io_status_sel) begin
            rd_data = pack_status(udf, ovf, out_full, !in_empty);
        end
    end

    assign bus = (io.c_ro && !reset) ? rd_data : 8'hzz;

endmodule
